// File: rtl/hilo_pkg.sv
// hilo_pkg: op codes, sequencer states and shared constants for the HI/LO multiply/divide unit
package hilo_pkg;
    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } hilo_op_e;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} hilo_state_e;

    localparam int DIV_ITERS = 32;

    function automatic logic is_signed_op(input logic [2:0] op);
        return op == OP_MULT || op == OP_DIV;
    endfunction
endpackage

// File: rtl/hilo_div_iter.sv
// hilo_div_iter: 32-iteration restoring divider on operand magnitudes, with sign fix-up
// and a one-cycle divide-by-zero bypass (lo = all ones, hi = raw dividend).
module hilo_div_iter
    import hilo_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic        i_signed,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_done,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);
    localparam int CW = $clog2(DIV_ITERS);

    logic          r_busy, r_zero, r_neg_q, r_neg_r;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_rem, r_quo, r_dvs, r_raw;
    logic [32:0]   w_sh, w_sub;
    logic          w_ge;
    logic [31:0]   w_rem, w_quo, w_a_mag, w_b_mag;

    always_comb begin
        w_a_mag = (i_signed && i_a[31]) ? -i_a : i_a;
        w_b_mag = (i_signed && i_b[31]) ? -i_b : i_b;
        w_sh    = {r_rem, r_quo[31]};
        w_sub   = w_sh - {1'b0, r_dvs};
        w_ge    = ~w_sub[32];
        w_rem   = w_ge ? w_sub[31:0] : w_sh[31:0];
        w_quo   = {r_quo[30:0], w_ge};
    end

    // Results are taken from the final iteration's next-state so the caller can latch them on the done edge
    assign o_done = r_busy && (r_zero || r_cnt == CW'(DIV_ITERS - 1));
    assign o_lo   = r_zero ? '1 : r_neg_q ? -w_quo : w_quo;
    assign o_hi   = r_zero ? r_raw : r_neg_r ? -w_rem : w_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_zero  <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_raw   <= '0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_zero  <= i_b == 32'd0;
            r_neg_q <= i_signed && (i_a[31] ^ i_b[31]);
            r_neg_r <= i_signed && i_a[31];
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_dvs   <= w_b_mag;
            r_raw   <= i_a;
        end else if (r_busy) begin
            r_busy  <= !(i_abort || o_done);
            r_cnt   <= r_cnt + CW'(1);
            r_rem   <= w_rem;
            r_quo   <= w_quo;
        end
    end
endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: EX-stage sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO that owns the HI/LO
// write port, stalls the pipeline while busy and keeps shadow HI/LO for merged writes.
module hilo_muldiv_ctrl
    import hilo_pkg::*;
#(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    hilo_state_e   r_state, w_state_n;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_a, r_b, r_hi, r_lo;
    logic          r_signed, r_we;
    logic          w_accept, w_mul_go, w_div_go, w_mthi, w_mtlo, w_mul_end, w_div_end;
    logic          w_div_done;
    logic [31:0]   w_div_hi, w_div_lo;
    logic [63:0]   w_prod;

    hilo_div_iter u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_div_go),
        .i_abort (flush_i),
        .i_signed(op_i == OP_DIV),
        .i_a     (rs_i),
        .i_b     (rt_i),
        .o_done  (w_div_done),
        .o_hi    (w_div_hi),
        .o_lo    (w_div_lo)
    );

    // Sign-extending to 64 bits makes one unsigned multiply serve both MULT and MULTU
    assign w_prod = {{32{r_signed & r_a[31]}}, r_a} * {{32{r_signed & r_b[31]}}, r_b};

    always_comb begin
        w_accept  = r_state == ST_IDLE && op_valid_i && !flush_i;
        w_mul_go  = w_accept && (op_i == OP_MULT || op_i == OP_MULTU);
        w_div_go  = w_accept && (op_i == OP_DIV || op_i == OP_DIVU);
        w_mthi    = w_accept && op_i == OP_MTHI;
        w_mtlo    = w_accept && op_i == OP_MTLO;
        w_mul_end = r_state == ST_MUL && r_cnt == CW'(MUL_CYCLES - 1) && !flush_i;
        w_div_end = r_state == ST_DIV && w_div_done && !flush_i;
        w_state_n = r_state;
        case (r_state)
            ST_IDLE: w_state_n = w_mul_go ? ST_MUL : w_div_go ? ST_DIV : ST_IDLE;
            ST_MUL:  w_state_n = flush_i ? ST_IDLE : w_mul_end ? ST_DONE : ST_MUL;
            ST_DIV:  w_state_n = flush_i ? ST_IDLE : w_div_end ? ST_DONE : ST_DIV;
            default: w_state_n = ST_IDLE;
        endcase
        stall_o   = w_mul_go || w_div_go || r_state == ST_MUL || r_state == ST_DIV;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_we     <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_we    <= w_mthi || w_mtlo || w_mul_end || w_div_end;
            if (w_mul_go) begin
                r_a      <= rs_i;
                r_b      <= rt_i;
                r_signed <= is_signed_op(op_i);
                r_cnt    <= '0;
            end else if (r_state == ST_MUL) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_mthi)
                r_hi <= rs_i;
            if (w_mtlo)
                r_lo <= rs_i;
            if (w_mul_end)
                {r_hi, r_lo} <= w_prod;
            if (w_div_end) begin
                r_hi <= w_div_hi;
                r_lo <= w_div_lo;
            end
        end
    end

    assign busy_o    = r_state != ST_IDLE;
    assign hilo_we_o = r_we;
    assign hi_o      = r_hi;
    assign lo_o      = r_lo;
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl: directed and randomized checks of the HI/LO sequencer against an arithmetic model
module tb_hilo_muldiv_ctrl;
    import hilo_pkg::*;

    localparam int MC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op_in = 3'd0;
    logic [31:0] rs = '0, rt = '0;
    logic        flush = 1'b0;
    logic        stall, busy, we;
    logic [31:0] hi, lo;
    logic [31:0] mhi = '0, mlo = '0;
    int          tests = 0, fails = 0;

    hilo_muldiv_ctrl #(.MUL_CYCLES(MC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid_i(op_valid),
        .op_i      (op_in),
        .rs_i      (rs),
        .rt_i      (rt),
        .flush_i   (flush),
        .stall_o   (stall),
        .busy_o    (busy),
        .hilo_we_o (we),
        .hi_o      (hi),
        .lo_o      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one op at posedge+1 and checks every cycle up to its write against the model
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat;
        bit md, wr;
        logic [31:0] eh, el;
        longint sa, sb;
        eh = mhi; el = mlo; lat = 1; md = 0; wr = 1;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MTHI:  eh = a;
            OP_MTLO:  el = a;
            OP_MULT:  begin {eh, el} = sa * sb; lat = MC + 1; md = 1; end
            OP_MULTU: begin {eh, el} = {32'd0, a} * {32'd0, b}; lat = MC + 1; md = 1; end
            OP_DIV, OP_DIVU: begin
                md = 1;
                if (b == 0) begin
                    el = '1; eh = a; lat = 2;
                end else begin
                    lat = 33;
                    el = (op == OP_DIV) ? 32'(sa / sb) : a / b;
                    eh = (op == OP_DIV) ? 32'(sa % sb) : a % b;
                end
            end
            default: wr = 0;
        endcase
        op_valid = 1; op_in = op; rs = a; rt = b;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            if (c == 0) check("busy_at_accept", 64'(busy), 64'd0);
            check("stall", 64'(stall), 64'(md && c < lat));
            check("we", 64'(we), 64'(wr && c == lat));
            check("hi", 64'(hi), 64'((c == lat) ? eh : mhi));
            check("lo", 64'(lo), 64'((c == lat) ? el : mlo));
            @(posedge clk); #1;
            if (!md) op_valid = 0;
        end
        op_valid = 0;
        mhi = eh; mlo = el;
    endtask

    task automatic expect_hl(input string tag, input logic [31:0] h, input logic [31:0] l);
        @(negedge clk);
        check({tag, "_hi"}, 64'(hi), 64'(h));
        check({tag, "_lo"}, 64'(lo), 64'(l));
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] edges [4] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000};
        return ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
    endfunction

    initial begin
        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_we", 64'(we), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;

        do_op(OP_MULT, 32'hFFFFFFFE, 32'd3);
        expect_hl("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);
        do_op(OP_MULTU, 32'hFFFFFFFE, 32'd3);
        expect_hl("multu", 32'h00000002, 32'hFFFFFFFA);
        do_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
        expect_hl("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op(OP_DIVU, 32'd7, 32'd2);
        expect_hl("divu", 32'd1, 32'd3);

        op_valid = 1; op_in = OP_MTHI; rs = 32'h1234;
        @(posedge clk); #1;
        op_in = OP_MTLO; rs = 32'h5678;
        @(negedge clk);
        check("mthi_we", 64'(we), 64'd1);
        check("mthi_hi", 64'(hi), 64'h1234);
        @(posedge clk); #1;
        op_valid = 0;
        @(negedge clk);
        check("mtlo_we", 64'(we), 64'd1);
        check("mtlo_hi", 64'(hi), 64'h1234);
        check("mtlo_lo", 64'(lo), 64'h5678);
        mhi = 32'h1234; mlo = 32'h5678;
        @(posedge clk); #1;

        op_valid = 1; op_in = OP_MTHI; rs = 32'hDEADBEEF; flush = 1;
        @(posedge clk); #1;
        op_valid = 0; flush = 0;
        @(negedge clk);
        check("idle_flush_we", 64'(we), 64'd0);
        check("idle_flush_hi", 64'(hi), 64'(mhi));
        @(posedge clk); #1;

        op_valid = 1; op_in = OP_DIVU; rs = 32'd100; rt = 32'd7;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("flush_pre_stall", 64'(stall), 64'd1);
            @(posedge clk); #1;
        end
        flush = 1;
        @(negedge clk);
        check("flush_stall", 64'(stall), 64'd1);
        @(posedge clk); #1;
        flush = 0;
        do_op(OP_MULT, 32'd6, 32'hFFFFFFF9);

        do_op(OP_DIV, 32'h55, 32'd0);
        expect_hl("div0", 32'h55, 32'hFFFFFFFF);
        do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        expect_hl("divovf", 32'd0, 32'h80000000);

        for (int i = 0; i < 40; i++)
            do_op(3'($urandom_range(0, 7)), pick(), pick());

        do_op(OP_MTHI, 32'hA5A5A5A5, 32'd0);
        op_valid = 1; op_in = OP_DIV; rs = 32'd1000; rt = 32'd3;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
        end
        op_valid = 0;
        @(negedge clk);
        check("pre_reset_busy", 64'(busy), 64'd1);
        #2 rst_n = 0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        @(negedge clk) rst_n = 1;
        mhi = '0; mlo = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            check("post_rst_we", 64'(we), 64'd0);
        end
        check("post_rst_hi", 64'(hi), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
